alu_muldiv_seq: RTL and testbench



---
 rtl/alu_muldiv_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Handshaked EX-stage execute unit: single-cycle base integer ops and
// iterative (one bit per cycle) RV32M multiply / divide / remainder.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [4:0]            op_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_SLL   = 5'b00010;
  localparam logic [4:0] OP_SRL   = 5'b00011;
  localparam logic [4:0] OP_SRA   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_SLT   = 5'b01000;
  localparam logic [4:0] OP_SLTU  = 5'b01001;
  localparam logic [4:0] OP_PASSB = 5'b01010;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      mop_q, mop_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [W-1:0]    res_q, res_d;
  logic            zero_q, zero_d;

  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       base_res;
  logic               is_m;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]       a_mag, b_mag;
  logic [W:0]         sum, trial;
  logic [W-1:0]       hi_n, lo_n;
  logic [W2-1:0]      prod, prod_s;
  logic [W-1:0]       q_s, r_s, fin_res;
  logic               div0;

  assign shamt   = B_i[SHAMT_W-1:0];
  assign is_m    = (op_i[4:3] == 2'b10);
  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign result_o = res_q;
  assign zero_o   = zero_q;

  always_comb begin
    base_res = '0;
    case (op_i)
      OP_ADD:   base_res = A_i + B_i;
      OP_SUB:   base_res = A_i - B_i;
      OP_SLL:   base_res = A_i << shamt;
      OP_SRL:   base_res = A_i >> shamt;
      OP_SRA:   base_res = $signed(A_i) >>> shamt;
      OP_AND:   base_res = A_i & B_i;
      OP_OR:    base_res = A_i | B_i;
      OP_XOR:   base_res = A_i ^ B_i;
      OP_SLT:   base_res = {{(W-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
      OP_SLTU:  base_res = {{(W-1){1'b0}}, (A_i < B_i)};
      OP_PASSB: base_res = B_i;
      default:  base_res = '0;
    endcase
  end

  // Operands are reduced to magnitudes at acceptance; signs are re-applied
  // only on the final iteration so latency never depends on the data.
  always_comb begin
    a_signed = (op_i[2:0] == 3'b001) || (op_i[2:0] == 3'b010) ||
               (op_i[2:0] == 3'b100) || (op_i[2:0] == 3'b110);
    b_signed = (op_i[2:0] == 3'b001) || (op_i[2:0] == 3'b100) ||
               (op_i[2:0] == 3'b110);
    a_neg    = a_signed && A_i[W-1];
    b_neg    = b_signed && B_i[W-1];
    a_mag    = a_neg ? (W'(0) - A_i) : A_i;
    b_mag    = b_neg ? (W'(0) - B_i) : B_i;
  end

  // Shared hi/lo datapath: shift-add multiply or restoring divide.
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    trial = {hi_q, lo_q[W-1]} - {1'b0, opb_q};
    if (!mop_q[2]) begin
      hi_n = sum[W:1];
      lo_n = {sum[0], lo_q[W-1:1]};
    end else if (!trial[W]) begin
      hi_n = trial[W-1:0];
      lo_n = {lo_q[W-2:0], 1'b1};
    end else begin
      hi_n = {hi_q[W-2:0], lo_q[W-1]};
      lo_n = {lo_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    div0    = (opb_q == '0);
    prod    = {hi_n, lo_n};
    prod_s  = (sa_q ^ sb_q) ? (W2'(0) - prod) : prod;
    q_s     = (sa_q ^ sb_q) ? (W'(0) - lo_n) : lo_n;
    r_s     = sa_q ? (W'(0) - hi_n) : hi_n;
    fin_res = '0;
    case (mop_q)
      3'b000:                 fin_res = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[W2-1:W];
      3'b100, 3'b101:         fin_res = div0 ? '1 : q_s;
      default:                fin_res = div0 ? dvd_q : r_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    dvd_d   = dvd_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (is_m) begin
            state_d = S_BUSY;
            cnt_d   = CW'(W);
            mop_d   = op_i[2:0];
            hi_d    = '0;
            lo_d    = a_mag;
            opb_d   = b_mag;
            dvd_d   = A_i;
            sa_d    = a_neg;
            sb_d    = b_neg;
          end else begin
            state_d = S_DONE;
            res_d   = base_res;
            zero_d  = (base_res == '0);
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        hi_d  = hi_n;
        lo_d  = lo_n;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = fin_res;
          zero_d  = (fin_res == '0);
        end
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mop_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      dvd_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      dvd_q   <= dvd_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq (DATA_WIDTH = 32).
module tb_alu_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  op_i;
  logic [31:0] A_i, B_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq #(.DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .A_i(A_i), .B_i(B_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Base-op vectors: op, A, B, expected result
  logic [4:0]  b_op [13] = '{5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01001,
                             5'b00010, 5'b00011, 5'b00101, 5'b00110, 5'b00111,
                             5'b01010, 5'b11111, 5'b00000};
  logic [31:0] b_a  [13] = '{32'd5, 32'd9, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd1, 32'h80000000, 32'h0000F0F0, 32'h0000F0F0, 32'h0000FFFF,
                             32'd0, 32'd1, 32'hFFFFFFFF};
  logic [31:0] b_b  [13] = '{32'd7, 32'd9, 32'h00000024, 32'd1, 32'd1,
                             32'h0000003F, 32'h0000001F, 32'h0000FF00, 32'h00000F0F, 32'h0000FFFF,
                             32'hDEADBEEF, 32'd1, 32'd1};
  logic [31:0] b_x  [13] = '{32'd12, 32'd0, 32'hF8000000, 32'd1, 32'd0,
                             32'h80000000, 32'd1, 32'h0000F000, 32'h0000FFFF, 32'd0,
                             32'hDEADBEEF, 32'd0, 32'd0};

  // M-op vectors
  logic [4:0]  m_op [16] = '{5'b10000, 5'b10001, 5'b10011, 5'b10010, 5'b10000, 5'b10001,
                             5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10100, 5'b10110,
                             5'b10100, 5'b10110, 5'b10100, 5'b10110};
  logic [31:0] m_a  [16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h80000000,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7};
  logic [31:0] m_b  [16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000,
                             32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd0, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE};
  logic [31:0] m_x  [16] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h40000000,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h80000000, 32'd0,
                             32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'd1};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request, wait (bounded) for valid_o; result left held (ready_i=0).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic rdy_seen);
    op_i = op; A_i = a; B_i = b; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    A_i = 32'hA5A5A5A5; B_i = 32'h5A5A5A5A;
    lat = 1;
    rdy_seen = 1'b0;
    while (!valid_o && lat < 100) begin
      if (ready_o) rdy_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0;
    op_i = 5'b00000; A_i = 32'd1; B_i = 32'd1;
    tick(); tick();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b result=%h zero=%b, need 1 0 0 0",
               ready_o, valid_o, result_o, zero_o);
    end
    reset_i = 1'b0; valid_i = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_valid_ignored: valid=%b ready=%b, need 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_base();
    int lat; logic rs;
    for (int i = 0; i < 13; i++) begin
      issue(b_op[i], b_a[i], b_b[i], lat, rs);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL base_latency[%0d]: got %0d, need 1", i, lat);
      end
      checks++;
      if (result_o !== b_x[i]) begin
        errors++;
        $display("FAIL base_result[%0d] op=%b: got %h, need %h", i, b_op[i], result_o, b_x[i]);
      end
      checks++;
      if (zero_o !== (b_x[i] == 32'd0)) begin
        errors++;
        $display("FAIL base_zero[%0d]: got %b, need %b", i, zero_o, (b_x[i] == 32'd0));
      end
      release_result();
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL base_return_idle[%0d]: ready=%b valid=%b, need 1 0", i, ready_o, valid_o);
      end
    end
  endtask

  task automatic test_muldiv();
    int lat; logic rs;
    for (int i = 0; i < 16; i++) begin
      issue(m_op[i], m_a[i], m_b[i], lat, rs);
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL m_latency[%0d]: got %0d, need 33", i, lat);
      end
      checks++;
      if (rs !== 1'b0) begin
        errors++;
        $display("FAIL m_ready_low[%0d]: ready_o seen high while busy, need low", i);
      end
      checks++;
      if (result_o !== m_x[i] || zero_o !== (m_x[i] == 32'd0)) begin
        errors++;
        $display("FAIL m_result[%0d] op=%b: got %h zero=%b, need %h zero=%b",
                 i, m_op[i], result_o, zero_o, m_x[i], (m_x[i] == 32'd0));
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    op_i = 5'b10101; A_i = 32'd100; B_i = 32'd7; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    cyc = 1;
    while (!valid_o && cyc < 100) begin
      valid_i = (cyc == 5 || cyc == 20);
      op_i = 5'b00000; A_i = 32'd1; B_i = 32'd1;
      tick();
      cyc++;
    end
    valid_i = 1'b0;
    checks++;
    if (cyc !== 33 || result_o !== 32'd14) begin
      errors++;
      $display("FAIL bp_divu: latency %0d result %h, need 33 0000000e", cyc, result_o);
    end
    for (int k = 0; k < 5; k++) begin
      valid_i = 1'b1; op_i = 5'b00001; A_i = 32'd3; B_i = 32'd3;
      tick();
      checks++;
      if (valid_o !== 1'b1 || result_o !== 32'd14 || zero_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h zero=%b, need 1 0000000e 0",
                 k, valid_o, result_o, zero_o);
      end
    end
    valid_i = 1'b0;
    release_result();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, need 0 1", valid_o, ready_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || result_o !== 32'd14) begin
      errors++;
      $display("FAIL bp_not_queued: valid=%b result=%h, need 0 0000000e", valid_o, result_o);
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic rs;
    op_i = 5'b10100; A_i = 32'd100; B_i = 32'd3; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd0 || zero_o !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: valid=%b ready=%b result=%h zero=%b, need 0 1 0 0",
               valid_o, ready_o, result_o, zero_o);
    end
    issue(5'b00000, 32'd1, 32'd1, lat, rs);
    checks++;
    if (lat !== 1 || result_o !== 32'd2) begin
      errors++;
      $display("FAIL post_reset_add: latency %0d result %h, need 1 00000002", lat, result_o);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic rs;
    issue(5'b10111, 32'd100, 32'd7, lat, rs);
    release_result();
    issue(5'b00111, 32'h0F0F0F0F, 32'hFFFFFFFF, lat, rs);
    checks++;
    if (lat !== 1 || result_o !== 32'hF0F0F0F0) begin
      errors++;
      $display("FAIL b2b_xor: latency %0d result %h, need 1 f0f0f0f0", lat, result_o);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_base();
    test_muldiv();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
